fp_rcp_pipe: RTL and testbench
==============================

Name: fp_rcp_pipe

Overview:
- Parametrised, fully pipelined floating-point reciprocal for the custom {sign, exp, mant} format used in the vertex/raster datapath.
- Generalises the fixed 22-bit reciprocal in three ways:
  - exponent and mantissa widths are parameters;
  - valid/ready back-pressure with a global stall is added;
  - sideband tags pass through alongside each result.
- Defined special-case handling: divide-by-zero flag with saturated output, and underflow flush-to-zero.
- Sits between the setup engine and the interpolator as the 1/w and edge-slope divider.

Parameters:
EXP_W, 5, exponent width; bias B = 2^(EXP_W-1)-1
FRAC_W, 16, mantissa width; MSB is an explicit leading one
LUT_A, 7, LUT index bits taken from mant[FRAC_W-2 -: LUT_A]
TAG_W, 4, sideband tag width

Ports:
clk  in  1  clock
rst_x  in  1  asynchronous active-low reset
i_valid  in  1  input operand valid
o_ready  out  1  block can accept an operand this cycle
i_a  in  1+EXP_W+FRAC_W  operand {s, e, m}
i_tag  in  TAG_W  sideband tag carried with the operand
o_valid  out  1  result valid
i_ready  in  1  downstream accepts the result
o_c  out  1+EXP_W+FRAC_W  result
o_tag  out  TAG_W  tag matching o_c
o_dz  out  1  divide-by-zero flag, qualified by o_valid

Behaviour:
- Reset (rst_x low, async): all stage valid bits = 0; o_valid = 0; o_c = 0; o_tag = 0; o_dz = 0. Data registers below the valid bits also clear.
- Pipeline: 3 stages, latency exactly 3 accepted cycles from the input handshake to o_valid.
  - S1: decode; register sign, tag, ce = 2B - e, low bits L = mant[FRAC_W-2-LUT_A:0], and zero/underflow flags. Drive the LUT address.
  - S2: synchronous LUT output; compute q = base - ((diff * L) >> LW), where LW = FRAC_W-1-LUT_A.
  - S3: normalise and select the special case; register o_c, o_tag, o_dz.
- Stall:
  - en = !o_valid | i_ready; o_ready = en.
  - When en = 0, every stage register and the LUT output hold.
  - A bubble (stage valid = 0) still advances whenever en = 1.
- Handshake: transfer in on i_valid & o_ready; transfer out on o_valid & i_ready.
  - o_c, o_tag and o_dz are stable while o_valid & !i_ready.
  - Simultaneous in and out transfers in one cycle are supported, giving a throughput of 1 per cycle.
- Normalise:
  - If q[FRAC_W-1] = 1: mant = q, exp = ce.
  - Otherwise: mant = q << 1, exp = ce - 1.
  - Exponent arithmetic is signed, EXP_W+2 bits wide.
- Special cases, in priority order:
  - e == 0 (zero input): o_c = {s, all ones}, o_dz = 1.
  - Normalised exp <= 0: o_c = {s, zeros} (signed zero), o_dz = 0.
  - Otherwise: {s, exp[EXP_W-1:0], mant}.
- Overflow is impossible, since ce <= 2B < 2^EXP_W - 1.
- Reset asserted mid-operation drops all in-flight operands. No partial result emerges after rst_x releases.
- Accuracy: the result is bit-exact to the algorithm above. It is within 2 ulp of the true reciprocal for the default parameters.

Decomposition:
- Shared package fp_pkg holds:
  - localparams B and LW;
  - field-extract functions for sign, exp and mant;
  - the stage payload typedef {sign, tag, ce, zero, L}.
- Sub-module fp_rcp_lut (clk, en, addr, base, diff) is a synchronous ROM with 2^LUT_A entries.
  - base(k) = round(2^(FRAC_W-1) / (1 + k*2^-LUT_A)), FRAC_W bits.
  - diff(k) = base(k) - base(k+1), with base(2^LUT_A) = 2^(FRAC_W-2).
  - Entries are generated by a function at elaboration, not a hex file.

Test Plan:
- 1.0 and 2.0: i_a = 0x0F8000 -> o_c = 0x0F8000; i_a = 0x108000 -> 0x0E8000. o_valid appears exactly 3 cycles after acceptance, o_dz = 0.
- 1.5 and -4.0: 0x0FC000 -> 0x0EAAAA (base(64) = 0x5555, left-shifted); 0x318000 -> 0x2D8000.
- Specials:
  - 0x000000 -> 0x1FFFFF, o_dz = 1.
  - 0x200000 -> 0x3FFFFF, o_dz = 1.
  - 0x1F8000 -> 0x000000.
  - 0x3EC000 (e = 30, mant != 1.0) -> 0x200000.
- Back-pressure:
  - Stream 8 operands with tags 0..7 while i_ready is toggled randomly.
  - Results must appear in order with matching tags, none dropped or duplicated.
  - Outputs hold steady while stalled.
  - o_ready = 0 exactly when o_valid & !i_ready.
- Full throughput: i_valid and i_ready held at 1 for 1000 random operands -> one result per cycle. Each result is bit-exact to the reference model and within 2 ulp of 1/x.
- Reset mid-stream: assert rst_x low with 3 operands in flight -> o_valid = 0 immediately (async). After release, no stale result appears, and the first new operand emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared format definitions for the custom {sign, exp, mant} float used by
// the reciprocal pipeline. The widths here define the pipeline payload, so
// the top-level parameters default to (and must match) these values.
package fp_pkg;

    localparam int FP_EXP_W  = 5;
    localparam int FP_FRAC_W = 16;
    localparam int FP_LUT_A  = 7;
    localparam int FP_TAG_W  = 4;

    localparam int FP_W = 1 + FP_EXP_W + FP_FRAC_W;
    // Signed exponent arithmetic needs headroom for 2B - e going negative.
    localparam int XW   = FP_EXP_W + 2;
    localparam int B    = (1 << (FP_EXP_W - 1)) - 1;
    // Interpolation fraction width: mantissa bits below the LUT index.
    localparam int LW   = FP_FRAC_W - 1 - FP_LUT_A;

    // Stage-1 payload: decoded operand waiting for the LUT read.
    typedef struct packed {
        logic                 sign;
        logic [FP_TAG_W-1:0]  tag;
        logic signed [XW-1:0] ce;
        logic                 zero;
        logic [LW-1:0]        l;
    } s1_t;

    // Stage-2 payload: interpolated quotient waiting for normalisation.
    typedef struct packed {
        logic                 sign;
        logic [FP_TAG_W-1:0]  tag;
        logic signed [XW-1:0] ce;
        logic                 zero;
        logic [FP_FRAC_W-1:0] q;
    } s2_t;

    function automatic logic f_sign(input logic [FP_W-1:0] a);
        return a[FP_W-1];
    endfunction

    function automatic logic [FP_EXP_W-1:0] f_exp(input logic [FP_W-1:0] a);
        return a[FP_W-2 -: FP_EXP_W];
    endfunction

    function automatic logic [FP_FRAC_W-1:0] f_mant(input logic [FP_W-1:0] a);
        return a[FP_FRAC_W-1:0];
    endfunction

endpackage

// File: rtl/fp_rcp_lut.sv
// Synchronous reciprocal ROM: segment start value and slope for linear
// interpolation of 1/m over [1,2). Contents are computed at elaboration.
module fp_rcp_lut #(
    parameter int FRAC_W = 16,
    parameter int LUT_A  = 7
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_A-1:0]  addr,
    output logic [FRAC_W-1:0] base,
    output logic [FRAC_W-1:0] diff
);

    localparam int N = 1 << LUT_A;

    // round(2^(FRAC_W-1) / (1 + k/N)) done in integers; ties cannot occur.
    function automatic logic [FRAC_W-1:0] base_of(input int k);
        longint num;
        longint den;
        num = longint'(1) << (FRAC_W - 1 + LUT_A);
        den = (longint'(1) << LUT_A) + longint'(k);
        return FRAC_W'((2 * num + den) / (2 * den));
    endfunction

    function automatic logic [N-1:0][FRAC_W-1:0] gen_base();
        logic [N-1:0][FRAC_W-1:0] t;
        for (int k = 0; k < N; k++) t[k] = base_of(k);
        return t;
    endfunction

    // base_of(N) is exactly 2^(FRAC_W-2), closing the last segment at 0.5.
    function automatic logic [N-1:0][FRAC_W-1:0] gen_diff();
        logic [N-1:0][FRAC_W-1:0] t;
        for (int k = 0; k < N; k++) t[k] = base_of(k) - base_of(k + 1);
        return t;
    endfunction

    localparam logic [N-1:0][FRAC_W-1:0] BASE_ROM = gen_base();
    localparam logic [N-1:0][FRAC_W-1:0] DIFF_ROM = gen_diff();

    // ROM read register; holds with the rest of the pipeline on stall.
    always_ff @(posedge clk) begin
        if (en) begin
            base <= BASE_ROM[addr];
            diff <= DIFF_ROM[addr];
        end
    end

endmodule

// File: rtl/fp_rcp_pipe.sv
// Three-stage pipelined floating-point reciprocal with valid/ready flow
// control, tag sideband, divide-by-zero saturation and underflow flush.
module fp_rcp_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int LUT_A  = FP_LUT_A,
    parameter int TAG_W  = FP_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_x,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [EXP_W+FRAC_W:0]   i_a,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [EXP_W+FRAC_W:0]   o_c,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_dz
);

    localparam int STAGES = 3;

    logic [STAGES:1]     vld_pipe;
    logic                en;
    s1_t                 s1_d, s1_q;
    s2_t                 s2_d, s2_q;
    logic [LUT_A-1:0]    lut_addr;
    logic [FRAC_W-1:0]   lut_base, lut_diff;
    logic [FRAC_W-1:0]   mant_in;
    logic [EXP_W-1:0]    exp_in;
    logic                unused_lead;
    logic [FRAC_W+LW-1:0] prod;
    logic [FRAC_W-1:0]   mant_n;
    logic signed [XW-1:0] exp_n;
    logic [EXP_W+FRAC_W:0] c_d;

    // The whole pipe advances together unless a finished result is stuck.
    assign en      = !vld_pipe[STAGES] || i_ready;
    assign o_ready = en;
    assign o_valid = vld_pipe[STAGES];

    // S1 decode: reflected exponent, interpolation fraction, zero detect.
    always_comb begin
        exp_in      = f_exp(i_a);
        mant_in     = f_mant(i_a);
        unused_lead = mant_in[FRAC_W-1];
        lut_addr    = mant_in[FRAC_W-2 -: LUT_A];
        s1_d.sign   = f_sign(i_a);
        s1_d.tag    = i_tag;
        s1_d.ce     = XW'(2 * B) - XW'(exp_in);
        s1_d.zero   = (exp_in == '0);
        s1_d.l      = mant_in[LW-1:0];
    end

    fp_rcp_lut #(
        .FRAC_W (FRAC_W),
        .LUT_A  (LUT_A)
    ) u_lut (
        .clk  (clk),
        .en   (en),
        .addr (lut_addr),
        .base (lut_base),
        .diff (lut_diff)
    );

    // Valid shift register; bubbles move along whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)  vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end

    // S1 payload register, loaded only by an accepted operand.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)             s1_q <= '0;
        else if (en && i_valid) s1_q <= s1_d;
    end

    // S2 interpolation: q = base - floor(diff * L / 2^LW).
    always_comb begin
        prod      = (FRAC_W+LW)'(lut_diff) * (FRAC_W+LW)'(s1_q.l);
        s2_d.sign = s1_q.sign;
        s2_d.tag  = s1_q.tag;
        s2_d.ce   = s1_q.ce;
        s2_d.zero = s1_q.zero;
        s2_d.q    = lut_base - FRAC_W'(prod >> LW);
    end

    // S2 payload register.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)                  s2_q <= '0;
        else if (en && vld_pipe[1])  s2_q <= s2_d;
    end

    // S3 normalise and pick the special case; zero input outranks flush.
    always_comb begin
        if (s2_q.q[FRAC_W-1]) begin
            mant_n = s2_q.q;
            exp_n  = s2_q.ce;
        end else begin
            mant_n = {s2_q.q[FRAC_W-2:0], 1'b0};
            exp_n  = s2_q.ce - XW'(1);
        end
        if (s2_q.zero)
            c_d = {s2_q.sign, {(EXP_W+FRAC_W){1'b1}}};
        else if (exp_n[XW-1] || exp_n == '0)
            c_d = {s2_q.sign, {(EXP_W+FRAC_W){1'b0}}};
        else
            c_d = {s2_q.sign, exp_n[EXP_W-1:0], mant_n};
    end

    // Output register; holds while the consumer is not ready.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            o_c   <= '0;
            o_tag <= '0;
            o_dz  <= 1'b0;
        end else if (en && vld_pipe[2]) begin
            o_c   <= c_d;
            o_tag <= s2_q.tag;
            o_dz  <= s2_q.zero;
        end
    end

endmodule

// File: tb/tb_fp_rcp_pipe.sv
// Self-checking bench for fp_rcp_pipe: directed values, back-pressure,
// full-rate random stream against a real-arithmetic model, mid-stream reset.
module tb_fp_rcp_pipe;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst_x = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_a = '0;
    logic [3:0]   i_tag = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_c;
    logic [3:0]   o_tag;
    logic         o_dz;

    fp_rcp_pipe dut (
        .clk     (clk),
        .rst_x   (rst_x),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_c     (o_c),
        .o_tag   (o_tag),
        .o_dz    (o_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [3:0]   tag;
        logic [W-1:0] c;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           nout = 0;
    logic         acc = 1'b0;
    logic         lat_chk = 1'b0;
    logic         ulp_chk = 1'b0;
    logic         expect_valid = 1'b0;
    logic         hold_pending = 1'b0;
    logic [W-1:0] held_c = '0;
    logic [3:0]   held_tag = '0;
    logic         held_dz = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference LUT entry from real arithmetic.
    function automatic int base_ref(input int k);
        return $rtoi(32768.0 / (1.0 + real'(k) / 128.0) + 0.5);
    endfunction

    // Reference result: linear interpolation of 1/m, normalise, specials.
    function automatic void model(input logic [W-1:0] a, output logic [W-1:0] c,
                                  output logic dz);
        int e, k, l, b0, b1, q, ex, mant;
        e  = int'(a[20:16]);
        k  = int'(a[14:8]);
        l  = int'(a[7:0]);
        dz = 1'b0;
        if (e == 0) begin
            dz = 1'b1;
            c  = {a[21], 21'h1FFFFF};
            return;
        end
        b0 = base_ref(k);
        b1 = base_ref(k + 1);
        q  = b0 - ((b0 - b1) * l) / 256;
        if (q >= 32768) begin
            mant = q;
            ex   = 30 - e;
        end else begin
            mant = 2 * q;
            ex   = 29 - e;
        end
        if (ex <= 0) c = {a[21], 21'h0};
        else         c = {a[21], 5'(ex), 16'(mant)};
    endfunction

    // Distance from the true 1/x, in ulps of the interpolator output scale
    // 2^(ce-B-15); flushed and saturated results are not measured.
    task automatic ulp_check(input logic [W-1:0] a, input logic [W-1:0] c, input logic dz);
        real xv, rv, err;
        int  e;
        if (dz || c[20:16] == 5'd0) return;
        e   = int'(a[20:16]);
        xv  = real'(a[15:0]) / 32768.0 * $pow(2.0, real'(e - 15));
        rv  = real'(c[15:0]) / 32768.0 * $pow(2.0, real'(int'(c[20:16]) - 15));
        err = (rv - 1.0 / xv) / $pow(2.0, real'(15 - e - 15));
        if (err < 0.0) err = -err;
        chk("ulp_bound", longint'(err <= 2.0), 1);
    endtask

    // One cycle: drive inputs at negedge, check outputs, score handshakes.
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [3:0] tag,
                        input logic rdy);
        exp_t e;
        i_valid = v;
        i_a     = a;
        i_tag   = tag;
        i_ready = rdy;
        #1;
        chk("o_ready", o_ready, !(o_valid && !rdy));
        if (expect_valid) chk("thru_valid", o_valid, 1);
        if (hold_pending) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_c", o_c, held_c);
            chk("hold_tag", o_tag, held_tag);
            chk("hold_dz", o_dz, held_dz);
        end
        if (o_valid && sb.size() == 0) begin
            chk("spurious_valid", o_valid, 0);
        end else if (o_valid && rdy) begin
            e = sb.pop_front();
            chk("result_c", o_c, e.c);
            chk("result_tag", o_tag, e.tag);
            chk("result_dz", o_dz, e.dz);
            nout++;
            if (lat_chk) chk("latency", cyc - e.cyc, 3);
            if (ulp_chk) ulp_check(e.a, o_c, o_dz);
        end
        acc = v && o_ready;
        if (acc) begin
            model(a, e.c, e.dz);
            e.a   = a;
            e.tag = tag;
            e.cyc = cyc;
            sb.push_back(e);
        end
        hold_pending = o_valid && !rdy;
        held_c       = o_c;
        held_tag     = o_tag;
        held_dz      = o_dz;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single operand against a fixed expected value, then drain.
    task automatic directed(input logic [W-1:0] a, input logic [3:0] tag,
                            input logic [W-1:0] c, input logic dz);
        tick(1'b1, a, tag, 1'b1);
        sb[sb.size()-1].c  = c;
        sb[sb.size()-1].dz = dz;
        repeat (4) tick(1'b0, '0, '0, 1'b1);
        chk("directed_drain", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_op();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b1, 15'($urandom)};
    endfunction

    initial begin
        int idx;

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_c", o_c, 0);
        chk("rst_tag", o_tag, 0);
        chk("rst_dz", o_dz, 0);
        chk("rst_ready", o_ready, 1);
        @(negedge clk);
        rst_x = 1'b1;

        // Directed values and specials, with exact latency.
        lat_chk = 1'b1;
        directed(22'h0F8000, 4'd1, 22'h0F8000, 1'b0);
        directed(22'h108000, 4'd2, 22'h0E8000, 1'b0);
        directed(22'h0FC000, 4'd3, 22'h0EAAAA, 1'b0);
        directed(22'h318000, 4'd4, 22'h2D8000, 1'b0);
        directed(22'h000000, 4'd5, 22'h1FFFFF, 1'b1);
        directed(22'h200000, 4'd6, 22'h3FFFFF, 1'b1);
        directed(22'h1F8000, 4'd7, 22'h000000, 1'b0);
        directed(22'h3EC000, 4'd8, 22'h200000, 1'b0);

        // Back-pressure: 8 tagged operands, random consumer readiness.
        lat_chk = 1'b0;
        nout    = 0;
        idx     = 0;
        for (int c = 0; c < 300 && !(idx == 8 && sb.size() == 0); c++) begin
            tick(idx < 8, rand_op(), 4'(idx), 1'($urandom_range(0, 1)));
            if (acc) idx++;
        end
        chk("bp_count", nout, 8);
        chk("bp_left", sb.size(), 0);

        // Full throughput: 1000 random operands, one result per cycle.
        lat_chk = 1'b1;
        ulp_chk = 1'b1;
        nout    = 0;
        for (int i = 0; i < 1003; i++) begin
            expect_valid = (i >= 3);
            tick(i < 1000, rand_op(), 4'(i), 1'b1);
        end
        expect_valid = 1'b0;
        ulp_chk      = 1'b0;
        chk("thru_count", nout, 1000);
        chk("thru_left", sb.size(), 0);

        // Mid-stream reset with three operands in flight.
        tick(1'b1, 22'h0F8000, 4'd9, 1'b1);
        tick(1'b1, 22'h108000, 4'd10, 1'b1);
        tick(1'b1, 22'h318000, 4'd11, 1'b1);
        #1;
        chk("pre_rst_valid", o_valid, 1);
        rst_x   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_c", o_c, 0);
        chk("midrst_tag", o_tag, 0);
        chk("midrst_dz", o_dz, 0);
        sb.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_x = 1'b1;
        repeat (6) tick(1'b0, '0, '0, 1'b1);
        directed(22'h0FC000, 4'd12, 22'h0EAAAA, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
